// File: rtl/activation_scheduler.sv
// ==== activation_scheduler : round-robin sharing of one Q1.15 activation unit among FMA lanes ====
// ==== optional perf counters: ACT_SCHED_PERF_EN                                   rev 1.0 ====
`default_nettype none

module activation_scheduler #(
    parameter int         NUM_LANES   = 4,
    parameter int         DATA_BITS   = 16,
    parameter int         ACT_LATENCY = 1,
    parameter logic [2:0] ACT_STATE   = 3'b110,
    parameter logic [2:0] IDLE_STATE  = 3'b000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LANES-1:0]           lane_req_valid,
    output logic [NUM_LANES-1:0]           lane_req_ready,
    input  logic [NUM_LANES*DATA_BITS-1:0] lane_unbiased,
    input  logic [NUM_LANES*DATA_BITS-1:0] lane_bias,
    output logic [NUM_LANES-1:0]           res_valid,
    output logic [NUM_LANES*DATA_BITS-1:0] res_data,
    input  logic                           cfg_write,
    input  logic                           cfg_act_enable,
    input  logic [1:0]                     cfg_act_func,
    output logic                           cfg_busy,
    output logic                           act_unit_enable,
    output logic [2:0]                     act_core_state,
    output logic                           act_activation_enable,
    output logic [1:0]                     act_activation_func,
    output logic [DATA_BITS-1:0]           act_unbiased,
    output logic [DATA_BITS-1:0]           act_bias,
    input  logic [DATA_BITS-1:0]           act_result,
    output logic [31:0]                    perf_issued,
    output logic [31:0]                    perf_stall
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_CFG_DRAIN = 2'd2,
        S_CFG_APPLY = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [NUM_LANES-1:0] pending, pending_next, take, grant_mask;
    logic [DATA_BITS-1:0] slot_unbiased [NUM_LANES];
    logic [DATA_BITS-1:0] slot_bias     [NUM_LANES];
    logic [LW-1:0]        rr_ptr, grant_lane, issue_lane;
    logic                 grant, can_grant, cfg_accept, pipe_empty;
    logic                 cfg_enable_q;
    logic [1:0]           cfg_func_q;
    logic [ACT_LATENCY-1:0] pipe_valid;
    logic [LW-1:0]        pipe_lane [ACT_LATENCY];
    int                   idx;

    assign lane_req_ready = (state == S_CFG_DRAIN) ? '0 : ~pending;
    assign take           = lane_req_valid & lane_req_ready;
    assign cfg_accept     = cfg_write && (state == S_IDLE || state == S_ISSUE);
    assign can_grant      = (state == S_IDLE || state == S_ISSUE) && !cfg_accept;
    assign cfg_busy       = (state == S_CFG_DRAIN) || (state == S_CFG_APPLY);
    // The issue register counts as in flight: its item has not entered the pipe yet.
    assign pipe_empty     = !act_unit_enable && (pipe_valid == '0);

    always_comb begin
        grant      = 1'b0;
        grant_lane = '0;
        idx        = 0;
        if (can_grant) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_LANES) idx = idx - NUM_LANES;
                if (!grant && pending[idx[LW-1:0]]) begin
                    grant      = 1'b1;
                    grant_lane = idx[LW-1:0];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) grant_mask[i] = grant && (grant_lane == LW'(i));
        pending_next = (pending & ~grant_mask) | take;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_ISSUE: begin
                if (cfg_accept)         state_next = S_CFG_DRAIN;
                else if (|pending_next) state_next = S_ISSUE;
                else                    state_next = S_IDLE;
            end
            S_CFG_DRAIN: if (pipe_empty) state_next = S_CFG_APPLY;
            S_CFG_APPLY: state_next = (|pending_next) ? S_ISSUE : S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state                 <= S_IDLE;
            pending               <= '0;
            rr_ptr                <= '0;
            cfg_enable_q          <= 1'b0;
            cfg_func_q            <= 2'b00;
            act_activation_enable <= 1'b0;
            act_activation_func   <= 2'b00;
            act_unit_enable       <= 1'b0;
            act_core_state        <= IDLE_STATE;
            act_unbiased          <= '0;
            act_bias              <= '0;
            issue_lane            <= '0;
            pipe_valid            <= '0;
            res_valid             <= '0;
            res_data              <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                slot_unbiased[i] <= '0;
                slot_bias[i]     <= '0;
            end
            for (int k = 0; k < ACT_LATENCY; k++) pipe_lane[k] <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (take[i]) begin
                    slot_unbiased[i] <= lane_unbiased[i*DATA_BITS +: DATA_BITS];
                    slot_bias[i]     <= lane_bias[i*DATA_BITS +: DATA_BITS];
                end
            end
            if (grant)
                rr_ptr <= (grant_lane == LW'(NUM_LANES - 1)) ? '0 : grant_lane + LW'(1);
            if (cfg_accept) begin
                cfg_enable_q <= cfg_act_enable;
                cfg_func_q   <= cfg_act_func;
            end
            if (state == S_CFG_APPLY) begin
                act_activation_enable <= cfg_enable_q;
                act_activation_func   <= cfg_func_q;
            end
            act_unit_enable <= grant;
            act_core_state  <= grant ? ACT_STATE : IDLE_STATE;
            if (grant) begin
                act_unbiased <= slot_unbiased[grant_lane];
                act_bias     <= slot_bias[grant_lane];
                issue_lane   <= grant_lane;
            end
            pipe_valid[0] <= act_unit_enable;
            pipe_lane[0]  <= issue_lane;
            for (int k = 1; k < ACT_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_lane[k]  <= pipe_lane[k-1];
            end
            res_valid <= '0;
            if (pipe_valid[ACT_LATENCY-1]) begin
                res_valid[pipe_lane[ACT_LATENCY-1]] <= 1'b1;
                res_data[pipe_lane[ACT_LATENCY-1]*DATA_BITS +: DATA_BITS] <= act_result;
            end
        end
    end

`ifdef ACT_SCHED_PERF_EN
    logic [31:0] issued_cnt, stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (act_unit_enable)          issued_cnt <= issued_cnt + 32'd1;
            if (cfg_busy && (|pending))   stall_cnt  <= stall_cnt + 32'd1;
        end
    end

    assign perf_issued = issued_cnt;
    assign perf_stall  = stall_cnt;
`else
    assign perf_issued = 32'd0;
    assign perf_stall  = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_activation_scheduler.sv
// ==== tb_activation_scheduler : vector table, directed corner sequences and a randomized
// ==== scoreboard run against an abstract scheduling model.                      rev 1.0
`default_nettype none

module tb_activation_scheduler;

    localparam int         N   = 4;
    localparam int         DB  = 16;
    localparam int         L   = 3;
    localparam logic [2:0] ACT = 3'b110;
    localparam logic [2:0] IDL = 3'b000;

    logic            clk, reset;
    logic [N-1:0]    lane_req_valid, lane_req_ready, res_valid;
    logic [N*DB-1:0] lane_unbiased, lane_bias, res_data;
    logic            cfg_write, cfg_act_enable, cfg_busy;
    logic [1:0]      cfg_act_func, act_activation_func;
    logic            act_unit_enable, act_activation_enable;
    logic [2:0]      act_core_state;
    logic [DB-1:0]   act_unbiased, act_bias, act_result;
    logic [31:0]     perf_issued, perf_stall;

    activation_scheduler #(
        .NUM_LANES(N), .DATA_BITS(DB), .ACT_LATENCY(L), .ACT_STATE(ACT), .IDLE_STATE(IDL)
    ) dut (
        .clk(clk), .reset(reset),
        .lane_req_valid(lane_req_valid), .lane_req_ready(lane_req_ready),
        .lane_unbiased(lane_unbiased), .lane_bias(lane_bias),
        .res_valid(res_valid), .res_data(res_data),
        .cfg_write(cfg_write), .cfg_act_enable(cfg_act_enable), .cfg_act_func(cfg_act_func),
        .cfg_busy(cfg_busy),
        .act_unit_enable(act_unit_enable), .act_core_state(act_core_state),
        .act_activation_enable(act_activation_enable), .act_activation_func(act_activation_func),
        .act_unbiased(act_unbiased), .act_bias(act_bias), .act_result(act_result),
        .perf_issued(perf_issued), .perf_stall(perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Saturating Q1.15 bias add followed by the selected activation.
    function automatic logic [15:0] act_fn(input logic [15:0] u, input logic [15:0] b,
                                           input logic en, input logic [1:0] f);
        int s;
        s = int'($signed(u)) + int'($signed(b));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (en) begin
            case (f)
                2'b01: if (s < 0) s = 0;
                2'b10: if (s < 0) s = s >>> 3;
                2'b11: begin if (s < 0) s = 0; if (s > 16384) s = 16384; end
                default: ;
            endcase
        end
        return 16'(s);
    endfunction

    // Behavioural activation unit with fixed latency L.
    logic [DB-1:0] ustage [L];
    always @(posedge clk) begin
        ustage[0] <= (act_unit_enable && act_core_state == ACT)
                     ? act_fn(act_unbiased, act_bias, act_activation_enable, act_activation_func)
                     : 16'hDEAD;
        for (int k = 1; k < L; k++) ustage[k] <= ustage[k-1];
    end
    assign act_result = ustage[L-1];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_cfg(input logic en, input logic [1:0] f);
        int n;
        cfg_write = 1'b1; cfg_act_enable = en; cfg_act_func = f;
        tick();
        cfg_write = 1'b0;
        check("cfg_busy_rise", cfg_busy, 1);
        n = 0;
        while (cfg_busy && n < 40) begin tick(); n++; end
        check("cfg_applied_en", act_activation_enable, en);
        check("cfg_applied_func", act_activation_func, f);
    endtask

    typedef struct {
        int          lane;
        logic [15:0] u, b;
        logic        en;
        logic [1:0]  f;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [8];

    typedef struct { int due; int lane; logic [15:0] d; } exp_t;
    exp_t expq [$];

    logic [N-1:0]  oh, mready, ev, mpend;
    logic [15:0]   mu [N];
    logic [15:0]   mb [N];
    logic [15:0]   du, dbias;
    logic          exp_issue;
    logic [15:0]   exp_u, exp_b;
    int            mrr, n, issue_cyc, model_issues, busy_cnt, res_got, idx;
    logic [31:0]   stall0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 16'h2000, 16'h1000, 1'b1, 2'b01, 16'h3000};
        tbl[1] = '{2, 16'h9000, 16'h0000, 1'b1, 2'b01, 16'h0000};
        tbl[2] = '{2, 16'h9000, 16'h0000, 1'b1, 2'b00, 16'h9000};
        tbl[3] = '{1, 16'h7000, 16'h2000, 1'b1, 2'b00, 16'h7FFF};
        tbl[4] = '{3, 16'h8000, 16'hF000, 1'b1, 2'b00, 16'h8000};
        tbl[5] = '{1, 16'hF000, 16'h0000, 1'b1, 2'b10, 16'hFE00};
        tbl[6] = '{0, 16'h6000, 16'h0000, 1'b1, 2'b11, 16'h4000};
        tbl[7] = '{3, 16'h9000, 16'h0000, 1'b0, 2'b01, 16'h9000};

        reset = 1'b0; lane_req_valid = '0; lane_unbiased = '0; lane_bias = '0;
        cfg_write = 1'b0; cfg_act_enable = 1'b0; cfg_act_func = 2'b00;
        tick(); tick();
        check("rst_ready", lane_req_ready, 4'hF);
        check("rst_unit_enable", act_unit_enable, 0);
        check("rst_core_state", act_core_state, IDL);
        check("rst_act_en", act_activation_enable, 0);
        check("rst_act_func", act_activation_func, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data[31:0], 0);
        check("rst_cfg_busy", cfg_busy, 0);
        check("rst_perf_issued", perf_issued, 0);
        check("rst_perf_stall", perf_stall, 0);
        reset = 1'b1;
        tick();

        // Vector table: one request per entry under its own configuration.
        for (int r = 0; r < 8; r++) begin
            do_cfg(tbl[r].en, tbl[r].f);
            oh = '0; oh[tbl[r].lane] = 1'b1;
            lane_unbiased[tbl[r].lane*DB +: DB] = tbl[r].u;
            lane_bias[tbl[r].lane*DB +: DB]     = tbl[r].b;
            check("vec_ready", lane_req_ready[tbl[r].lane], 1);
            lane_req_valid = oh;
            tick();
            lane_req_valid = '0;
            n = 0;
            while (!act_unit_enable && n < 10) begin tick(); n++; end
            issue_cyc = cyc;
            check("vec_issue_seen", act_unit_enable, 1);
            check("vec_issue_state", act_core_state, ACT);
            check("vec_issue_u", act_unbiased, tbl[r].u);
            check("vec_issue_b", act_bias, tbl[r].b);
            n = 0;
            while (res_valid == '0 && n < 12) begin tick(); n++; end
            check("vec_latency", cyc - issue_cyc, L + 1);
            check("vec_res_valid", res_valid, oh);
            check("vec_res_data", res_data[tbl[r].lane*DB +: DB], tbl[r].exp);
            tick();
            check("vec_pulse_end", res_valid, 0);
        end

        // Randomized run against the scheduling model (config fixed at LeakyReLU).
        reset = 1'b0; tick(); reset = 1'b1; tick();
        do_cfg(1'b1, 2'b10);
        mpend = '0; mrr = 0; exp_issue = 1'b0; model_issues = 0; expq.delete();
        for (int n2 = 0; n2 < 380; n2++) begin
            check("rnd_issue", act_unit_enable, exp_issue);
            if (exp_issue) begin
                check("rnd_issue_u", act_unbiased, exp_u);
                check("rnd_issue_b", act_bias, exp_b);
            end
            mready = ~mpend;
            check("rnd_ready", lane_req_ready, mready);
            ev = '0;
            for (int j = expq.size() - 1; j >= 0; j--) begin
                if (expq[j].due == n2) begin
                    ev[expq[j].lane] = 1'b1;
                    check("rnd_res_data", res_data[expq[j].lane*DB +: DB], expq[j].d);
                    expq.delete(j);
                end
            end
            check("rnd_res_valid", res_valid, ev);
            exp_issue = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (mrr + k) % N;
                if (!exp_issue && mpend[idx]) begin
                    exp_issue = 1'b1;
                    exp_u = mu[idx]; exp_b = mb[idx];
                    mpend[idx] = 1'b0;
                    mrr = (idx + 1) % N;
                    model_issues++;
                    expq.push_back('{n2 + L + 2, idx, act_fn(mu[idx], mb[idx], 1'b1, 2'b10)});
                end
            end
            if (n2 < 60)       lane_req_valid = '1;
            else if (n2 < 360) lane_req_valid = N'($urandom);
            else               lane_req_valid = '0;
            for (int i = 0; i < N; i++) begin
                du = 16'($urandom); dbias = 16'($urandom);
                lane_unbiased[i*DB +: DB] = du;
                lane_bias[i*DB +: DB]     = dbias;
                if (lane_req_valid[i] && mready[i]) begin
                    mpend[i] = 1'b1; mu[i] = du; mb[i] = dbias;
                end
            end
            tick();
        end
        check("rnd_all_returned", expq.size(), 0);
`ifdef ACT_SCHED_PERF_EN
        check("perf_issued_count", perf_issued, model_issues);
`else
        check("perf_issued_tied", perf_issued, 0);
        check("perf_stall_tied", perf_stall, 0);
`endif

        // Config change with two items in flight and one slot pending.
        do_cfg(1'b1, 2'b01);
        lane_unbiased = '0; lane_bias = '0;
        lane_unbiased[0*DB +: DB] = 16'h6000;
        lane_unbiased[1*DB +: DB] = 16'h5000; lane_bias[1*DB +: DB] = 16'h1000;
        lane_req_valid = 4'b0011;
        tick();
        lane_req_valid = '0;
        tick();
        lane_unbiased[2*DB +: DB] = 16'h6000;
        lane_req_valid = 4'b0100;
        tick();
        lane_req_valid = '0;
        check("drain_second_issue", act_unit_enable, 1);
        stall0 = perf_stall;
        cfg_write = 1'b1; cfg_act_enable = 1'b1; cfg_act_func = 2'b11;
        tick();
        cfg_write = 1'b0;
        lane_unbiased[3*DB +: DB] = 16'h7000;
        lane_req_valid = 4'b1000;
        busy_cnt = 0; res_got = 0;
        while (cfg_busy && busy_cnt < 20) begin
            busy_cnt++;
            check("drain_no_issue", act_unit_enable, 0);
            if (busy_cnt <= 4) check("drain_ready_low", lane_req_ready, 0);
            else               check("apply_ready3", lane_req_ready[3], 1);
            for (int i = 0; i < 2; i++) begin
                if (res_valid[i]) begin
                    res_got++;
                    check("drain_old_func_data", res_data[i*DB +: DB], 16'h6000);
                    check("drain_func_held", act_activation_func, 2'b01);
                end
            end
            cfg_write = (busy_cnt == 2);
            cfg_act_func = (busy_cnt == 2) ? 2'b00 : 2'b11;
            tick();
        end
        cfg_write = 1'b0;
        lane_req_valid = '0;
        check("drain_busy_cycles", busy_cnt, 5);
        check("drain_results_old", res_got, 2);
        check("drain_new_func", act_activation_func, 2'b11);
`ifdef ACT_SCHED_PERF_EN
        check("perf_stall_drain", perf_stall - stall0, 5);
`else
        check("perf_stall_tied2", perf_stall, stall0);
`endif
        res_got = 0; n = 0;
        while (res_got < 2 && n < 20) begin
            for (int i = 2; i < 4; i++) begin
                if (res_valid[i]) begin
                    res_got++;
                    check("post_cfg_data", res_data[i*DB +: DB], 16'h4000);
                end
            end
            tick(); n++;
        end
        check("post_cfg_results", res_got, 2);
        for (int k = 0; k < 10; k++) tick();

        // Reset with two items in flight and three slots pending.
        reset = 1'b0; tick(); reset = 1'b1; tick();
        lane_req_valid = 4'hF;
        tick();
        lane_req_valid = '0;
        tick();
        lane_req_valid = lane_req_ready;
        tick();
        lane_req_valid = '0;
        check("mid_inflight", act_unit_enable, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("mid_no_result", res_valid, 0);
            check("mid_idle_enable", act_unit_enable, 0);
            check("mid_idle_state", act_core_state, IDL);
            check("mid_ready", lane_req_ready, 4'hF);
            tick();
        end
        lane_unbiased[1*DB +: DB] = 16'h1111;
        lane_unbiased[3*DB +: DB] = 16'h3333;
        lane_req_valid = 4'b1010;
        tick();
        lane_req_valid = '0;
        tick();
        check("rr_after_reset_first", act_unbiased, 16'h1111);
        tick();
        check("rr_after_reset_second", act_unbiased, 16'h3333);
        for (int k = 0; k < 8; k++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/activation_scheduler.md
Name: activation_scheduler

Overview:
- Shares one activation unit (Q1.15 bias-add plus ReLU / LeakyReLU / ClippedReLU) among NUM_LANES FMA lanes.
- Buffers one request per lane and grants lanes round-robin, one issue per cycle. Drives the unit's control and data inputs, then returns each result to its originating lane after a fixed latency.
- Owns the activation configuration (enable, func). Changes to it are applied only after the in-flight pipeline has drained.

Parameters:
- NUM_LANES, 4, number of requesting lanes (2..8)
- DATA_BITS, 16, Q1.15 data width
- ACT_LATENCY, 1, cycles from issue to valid act_result (1..4)
- ACT_STATE, 3'b110, core_state value that makes the unit compute
- IDLE_STATE, 3'b000, core_state value driven when not issuing

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low: state clears on a rising edge of clk while reset==0
- lane_req_valid  in  NUM_LANES  per-lane request valid
- lane_req_ready  out  NUM_LANES  per-lane request ready
- lane_unbiased  in  NUM_LANES*DATA_BITS  packed FMA results, lane i at [i*DATA_BITS +: DATA_BITS]
- lane_bias  in  NUM_LANES*DATA_BITS  packed bias values, same packing
- res_valid  out  NUM_LANES  one-cycle result pulse per lane
- res_data  out  NUM_LANES*DATA_BITS  packed results; lane i field valid while res_valid[i]
- cfg_write  in  1  request a configuration change
- cfg_act_enable  in  1  new activation_enable value
- cfg_act_func  in  2  new func (00 none, 01 ReLU, 10 LeakyReLU, 11 ClippedReLU)
- cfg_busy  out  1  high while a configuration change is pending
- act_unit_enable  out  1  enable to the activation unit
- act_core_state  out  3  core_state to the activation unit
- act_activation_enable  out  1  current applied enable
- act_activation_func  out  2  current applied func
- act_unbiased  out  DATA_BITS  issued operand
- act_bias  out  DATA_BITS  issued bias
- act_result  in  DATA_BITS  activation unit output
- perf_issued  out  32  issue counter (see Optional Feature)
- perf_stall  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset values:
  - All outputs 0, with act_core_state=IDLE_STATE, act_activation_enable=0 and act_activation_func=00.
  - Pending slots empty, round-robin pointer=0, in-flight pipe cleared, FSM=IDLE.
  - Reset mid-operation discards every buffered and in-flight item; no res_valid pulses follow reset.
- Request buffer:
  - Each lane has one pending slot. lane_req_ready[i] = !pending[i] && state!=CFG_DRAIN (registered state, no combinational dependence on valid).
  - A transfer occurs when valid&&ready, capturing lane_unbiased[i] and lane_bias[i].
  - A slot freed by issue in cycle t shows ready=1 in cycle t+1; there is no same-cycle refill. Per-lane throughput is therefore 1 per 2 cycles.
- Arbitration:
  - Round-robin over pending slots, starting search at rr_ptr. At most one grant per cycle.
  - After a grant to lane g, rr_ptr=(g+1) mod NUM_LANES. rr_ptr is unchanged when there is no grant.
- Issue cycle:
  - act_unit_enable=1, act_core_state=ACT_STATE, act_unbiased and act_bias taken from the granted slot.
  - Outputs are registered: a grant decided in cycle t drives the unit in cycle t+1.
  - In non-issue cycles: act_unit_enable=0, act_core_state=IDLE_STATE, data outputs hold their last values.
- Return path:
  - A shift pipe of depth ACT_LATENCY carries {valid, lane_id}.
  - When the tail is valid, act_result is registered into res_data[lane] and res_valid[lane] pulses for exactly one cycle. res_valid therefore rises ACT_LATENCY+1 cycles after the unit-issue cycle.
  - Lanes must accept results; there is no backpressure.
- FSM:
  - IDLE -> ISSUE when any slot is pending.
  - ISSUE -> IDLE when no slot is pending after the grant.
  - IDLE/ISSUE -> CFG_DRAIN on cfg_write. The cfg values are latched, and cfg_write has priority over new grants that cycle.
  - CFG_DRAIN: no grants, lane_req_ready=0, the in-flight pipe continues to drain.
  - CFG_DRAIN -> CFG_APPLY when the pipe is empty. CFG_APPLY updates act_activation_enable/func, then goes to ISSUE if any slot is pending, else IDLE.
  - cfg_busy=1 from the cycle after cfg_write until the cycle after CFG_APPLY.
  - cfg_write while cfg_busy is ignored.
- Applied configuration never changes while any item is in flight.

Optional Feature:
- Macro ACT_SCHED_PERF_EN.
- Defined:
  - perf_issued increments on every unit-issue cycle.
  - perf_stall increments on every cycle in which any pending slot exists but no grant occurs (CFG_DRAIN/CFG_APPLY).
  - Both counters are 32-bit, wrap at 2^32-1 -> 0, and clear on reset.
- Not defined: perf_issued and perf_stall are tied to 0 and no counter flops exist.

Test Plan:
- Single lane: cfg func=01 enable=1 applied; lane0 sends unbiased=0x2000, bias=0x1000; unit model returns saturated sum (ReLU) with ACT_LATENCY=1 -> exactly one res_valid[0] pulse with res_data0=0x3000, 2 cycles after the unit-issue cycle.
- Fairness: all 4 lanes valid continuously with distinct data -> grant order 0,1,2,3,0,...; each lane gets 1 result per 4 issues; act_unit_enable high every cycle once full.
- Negative clamp: lane2 sends unbiased=0x9000, bias=0x0000 under ReLU -> res_data2=0x0000; under func=00 -> res_data2=0x9000.
- Config drain: ACT_LATENCY=3, two items in flight, cfg_write func=11 -> both results returned under the old func; no issue and lane_req_ready=0 during the drain; func updated after the pipe empties; cfg_busy covers exactly the drain plus apply window.
- Reset mid-flight: pull reset=0 for 1 cycle with 2 items in flight and 3 slots pending -> no res_valid afterwards, all ready=1, act_core_state=IDLE_STATE, rr_ptr=0.
- ACT_SCHED_PERF_EN: 10 issues plus a 3-cycle drain stall with pending slots -> perf_issued=10, perf_stall=3; without the macro both read 0.
